// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone interconnect and related masters.
package wb_pkg;

    typedef enum logic {
        IC_IDLE = 1'b0,
        IC_BUSY = 1'b1
    } IcState;

    localparam logic [31:0] WB_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts run cycles since the last clear and flags when the
// count has reached TIMEOUT while still running.
module wb_watchdog
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int              CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up while running and saturate at LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (run && (cnt_q != LIMIT))
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = run && (cnt_q == LIMIT);

endmodule

// File: rtl/wb_interconnect.sv
// Single-master, N-slave Wishbone B4 pipelined interconnect. One transaction
// outstanding at a time; a watchdog guarantees every request gets an ack.
module wb_interconnect
    import wb_pkg::*;
#(
    parameter int          NSLAVES   = 4,
    parameter int          SEL_LSB   = 8,
    parameter int          SEL_WIDTH = 2,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = WB_ERR_DATA
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [15:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic [31:0]             wbs_dat_o,
    output logic                    wbs_stall_o,
    output logic                    wbs_ack_o,
    output logic [NSLAVES-1:0]      wbm_cyc_o,
    output logic [NSLAVES-1:0]      wbm_stb_o,
    output logic                    wbm_we_o,
    output logic [3:0]              wbm_sel_o,
    output logic [15:0]             wbm_adr_o,
    output logic [31:0]             wbm_dat_o,
    input  logic [32*NSLAVES-1:0]   wbm_dat_i,
    input  logic [NSLAVES-1:0]      wbm_stall_i,
    input  logic [NSLAVES-1:0]      wbm_ack_i
);

    IcState               state_q, state_d;
    logic [NSLAVES-1:0]   cyc_q, cyc_d;
    logic [NSLAVES-1:0]   stb_q, stb_d;
    logic                 we_q, we_d;
    logic [3:0]           sel_q, sel_d;
    logic [15:0]          adr_q, adr_d;
    logic [31:0]          dat_q, dat_d;
    logic                 ack_q, ack_d;
    logic [31:0]          rdata_q, rdata_d;

    logic [SEL_WIDTH-1:0] sel_idx;
    logic [NSLAVES-1:0]   dec;
    logic                 mapped;
    logic                 slv_ack, slv_stall;
    logic [31:0]          slv_dat;
    logic                 wd_clear, wd_run, wd_expired;

    assign sel_idx = wbs_adr_i[SEL_LSB +: SEL_WIDTH];

    // Address decode to one-hot slave select; an index past NSLAVES decodes to nothing.
    always_comb begin
        dec = '0;
        for (int k = 0; k < NSLAVES; k++)
            dec[k] = (int'(sel_idx) == k);
        mapped = |dec;
    end

    // Selected-slave response mux, keyed off the one-hot cyc register so
    // non-selected slaves can never leak ack/stall/data into the master.
    always_comb begin
        slv_dat = '0;
        for (int k = 0; k < NSLAVES; k++)
            if (cyc_q[k]) slv_dat = slv_dat | wbm_dat_i[32*k +: 32];
        slv_ack   = |(wbm_ack_i & cyc_q);
        slv_stall = |(wbm_stall_i & cyc_q);
    end

    // Next-state and output logic. In BUSY: abort beats ack, ack beats timeout.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        we_d     = we_q;
        sel_d    = sel_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        ack_d    = 1'b0;
        rdata_d  = rdata_q;
        wd_clear = 1'b0;
        case (state_q)
            IC_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    we_d  = wbs_we_i;
                    sel_d = wbs_sel_i;
                    adr_d = wbs_adr_i;
                    dat_d = wbs_dat_i;
                    if (mapped) begin
                        cyc_d    = dec;
                        stb_d    = dec;
                        wd_clear = 1'b1;
                        state_d  = IC_BUSY;
                    end else begin
                        ack_d   = 1'b1;
                        rdata_d = ERR_DATA;
                    end
                end
            end
            IC_BUSY: begin
                if (!wbs_cyc_i) begin
                    cyc_d   = '0;
                    stb_d   = '0;
                    state_d = IC_IDLE;
                end else if (slv_ack) begin
                    ack_d   = 1'b1;
                    rdata_d = slv_dat;
                    cyc_d   = '0;
                    stb_d   = '0;
                    state_d = IC_IDLE;
                end else if (wd_expired) begin
                    ack_d   = 1'b1;
                    rdata_d = ERR_DATA;
                    cyc_d   = '0;
                    stb_d   = '0;
                    state_d = IC_IDLE;
                end else if (!slv_stall) begin
                    stb_d = '0;
                end
            end
            default: state_d = IC_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IC_IDLE;
            cyc_q   <= '0;
            stb_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign wd_run = (state_q == IC_BUSY);

    wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (wd_clear),
        .run     (wd_run),
        .expired (wd_expired)
    );

    assign wbs_stall_o = (state_q != IC_IDLE);
    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = rdata_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;

endmodule
